// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data load/store requester. Data accesses win over fetches when both
// wait in IDLE. Every bus cycle is registered and held until mem_ready is
// sampled. The requester sees a one-cycle done pulse that drops its stall.
// An IDLE cycle separates consecutive transactions.
//
// Optional build macro: FETCH_BUF_EN adds a one-entry fetch buffer
// (valid/tag/word). A repeated fetch of the last fetched address is then
// served without a bus cycle. A completed store to that address invalidates
// the entry.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   i_req/i_addr       fetch request and address (held while stalled)
//   i_rdata/i_stall    fetched word, fetch-pending indication
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_rdata/d_stall    load result, data-pending indication
//   mem_req/mem_we/mem_addr/mem_wdata  registered shared memory request
//   mem_rdata/mem_ready                memory read data and completion
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] INST = 2'd2;

    logic [1:0] state;
    logic       iDone;
    logic       dDone;
    // Set once the owner of the current bus cycle lets go of its request.
    // The cycle still finishes on the bus, but its result is dropped.
    logic       xferAbort;
    logic       reqLive;

`ifdef FETCH_BUF_EN
    logic              bufValid;
    logic [ADDR_W-1:0] bufTag;
    logic [DATA_W-1:0] bufWord;
    logic              bufHit;

    assign bufHit = bufValid && (i_addr == bufTag);
`endif

    assign i_stall = i_req & ~iDone;
    assign d_stall = d_req & ~dDone;
    assign reqLive = (state == DATA) ? d_req : i_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            iDone     <= 1'b0;
            dDone     <= 1'b0;
            xferAbort <= 1'b0;
`ifdef FETCH_BUF_EN
            bufValid  <= 1'b0;
`endif
        end else begin
            // Done flags are single-cycle pulses.
            iDone <= 1'b0;
            dDone <= 1'b0;
            case (state)
                IDLE: begin
                    // A request whose done flag is high is the one that just
                    // completed, so it is not granted again.
                    if (d_req && !dDone) begin
                        state     <= DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        xferAbort <= 1'b0;
                    end else if (i_req && !iDone) begin
`ifdef FETCH_BUF_EN
                        if (bufHit) begin
                            iDone   <= 1'b1;
                            i_rdata <= bufWord;
                        end else begin
                            state     <= INST;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            xferAbort <= 1'b0;
                        end
`else
                        state     <= INST;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        xferAbort <= 1'b0;
`endif
                    end
                end
                DATA, INST: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!xferAbort && reqLive) begin
                            if (state == DATA) begin
                                dDone <= 1'b1;
                                if (!mem_we) begin
                                    d_rdata <= mem_rdata;
                                end
                            end else begin
                                iDone   <= 1'b1;
                                i_rdata <= mem_rdata;
                            end
                        end
`ifdef FETCH_BUF_EN
                        // The buffer refills even on a discarded fetch: the
                        // word read from memory is still correct.
                        if (state == INST) begin
                            bufValid <= 1'b1;
                        end else if (mem_we && (mem_addr == bufTag)) begin
                            bufValid <= 1'b0;
                        end
`endif
                    end else if (!reqLive) begin
                        xferAbort <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_BUF_EN
    // Tag and word are qualified by bufValid, so they do not need a reset.
    always_ff @(posedge clk) begin
        if ((state == INST) && mem_ready) begin
            bufTag  <= mem_addr;
            bufWord <= mem_rdata;
        end
    end
`endif

endmodule
